// File: rtl/if_pkg.sv
// Shared state encodings and constants for the instruction fetch stage.
package if_pkg;

  typedef logic [1:0] if_state_t;

  localparam if_state_t ST_FETCH = 2'd0;
  localparam if_state_t ST_FLUSH = 2'd1;
  localparam if_state_t ST_HALT  = 2'd2;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect and decode handshake.
// if_misalign exists only when IF_MISALIGN_TRAP_EN is defined.
interface instruction_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  modport master (
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, if_ready,
`ifdef IF_MISALIGN_TRAP_EN
    output if_misalign,
`endif
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, if_ready,
`ifdef IF_MISALIGN_TRAP_EN
    input  if_misalign,
`endif
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc
  );

endinterface

// File: rtl/instruction_fetch_sync_fifo.sv
// Synchronous FIFO with clear; count_o reports occupancy 0..DEPTH. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_EMPTY = {(AW+1){1'b0}};
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Overflow/underflow attempts are ignored rather than corrupting the pointers.
  assign push_ok_s = push_i && (count_q != CNT_FULL);
  assign pop_ok_s  = pop_i && (count_q != CNT_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_EMPTY;
    end else if (clr_i) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_EMPTY;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_q + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I instruction fetch: owns fetch_pc, issues credit-limited imem reads, queues {pc, instr} for decode.
// Optional IF_MISALIGN_TRAP_EN: a misaligned redirect emits one trap entry and halts fetch until the next redirect.
module instruction_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IF_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus_io
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef IF_MISALIGN_TRAP_EN
  localparam int OQ_W = 65;
`else
  localparam int OQ_W = 64;
`endif
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  if_state_t     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] pcq_count_s;
  logic [CW-1:0] oq_count_s;
  logic [31:0]   pcq_head_s;
  logic [OQ_W-1:0] oq_din_s;
  logic [OQ_W-1:0] oq_head_s;
  logic          credit_ok_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_take_s;
  logic          oq_push_s;
  logic          oq_pop_s;
  logic [CW-1:0] rsp_dec_s;
  logic [CW-1:0] redir_drop_s;
  if_state_t     flush_exit_s;

  // Credits use registered counts only, so a same-cycle pop never frees a slot early.
  assign credit_ok_s = (({1'b0, inflight_q} + {1'b0, oq_count_s}) < CREDIT_MAX);
  assign req_valid_s = !rst && (state_q == ST_FETCH) && credit_ok_s && !bus_io.redirect_valid;
  assign req_fire_s  = req_valid_s && bus_io.imem_req_ready;
  assign rsp_take_s  = bus_io.imem_rsp_valid && !bus_io.redirect_valid &&
                       (state_q == ST_FETCH) && (pcq_count_s != CNT_ZERO);
  assign oq_pop_s    = bus_io.if_valid && bus_io.if_ready;
  assign rsp_dec_s   = bus_io.imem_rsp_valid ? CNT_ONE : CNT_ZERO;
  assign redir_drop_s = inflight_q - rsp_dec_s;

`ifdef IF_MISALIGN_TRAP_EN
  logic        trap_pend_q, trap_pend_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        trap_push_s;

  assign trap_push_s  = (state_q == ST_HALT) && trap_pend_q;
  assign oq_push_s    = rsp_take_s || trap_push_s;
  assign oq_din_s     = trap_push_s ? {1'b1, trap_pc_q, NOP_INSTR}
                                    : {1'b0, pcq_head_s, bus_io.imem_rsp_data};
  assign flush_exit_s = trap_pend_q ? ST_HALT : ST_FETCH;
  assign bus_io.if_misalign = oq_head_s[64];
`else
  assign oq_push_s    = rsp_take_s;
  assign oq_din_s     = {pcq_head_s, bus_io.imem_rsp_data};
  assign flush_exit_s = ST_FETCH;
`endif

  // Next-state logic; a redirect overrides whatever the current state would do.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
`ifdef IF_MISALIGN_TRAP_EN
    trap_pend_d = trap_pend_q;
    trap_pc_d   = trap_pc_q;
`endif
    if (bus_io.redirect_valid) begin
      fetch_pc_d = word_align(bus_io.redirect_pc);
      drop_cnt_d = redir_drop_s;
      inflight_d = redir_drop_s;
`ifdef IF_MISALIGN_TRAP_EN
      if (bus_io.redirect_pc[1:0] != 2'b00) begin
        trap_pend_d = 1'b1;
        trap_pc_d   = bus_io.redirect_pc;
        state_d     = (redir_drop_s != CNT_ZERO) ? ST_FLUSH : ST_HALT;
      end else begin
        trap_pend_d = 1'b0;
        state_d     = (redir_drop_s != CNT_ZERO) ? ST_FLUSH : ST_FETCH;
      end
`else
      state_d = (redir_drop_s != CNT_ZERO) ? ST_FLUSH : ST_FETCH;
`endif
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            fetch_pc_d = fetch_pc_q;
          end
          inflight_d = inflight_q + (req_fire_s ? CNT_ONE : CNT_ZERO)
                                  - (rsp_take_s ? CNT_ONE : CNT_ZERO);
          state_d    = ST_FETCH;
        end
        ST_FLUSH: begin
          if (bus_io.imem_rsp_valid && (drop_cnt_q != CNT_ZERO)) begin
            drop_cnt_d = drop_cnt_q - CNT_ONE;
            inflight_d = inflight_q - CNT_ONE;
          end else begin
            drop_cnt_d = drop_cnt_q;
            inflight_d = inflight_q;
          end
          if (drop_cnt_d == CNT_ZERO) begin
            state_d = flush_exit_s;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        ST_HALT: begin
`ifdef IF_MISALIGN_TRAP_EN
          state_d     = ST_HALT;
          trap_pend_d = trap_push_s ? 1'b0 : trap_pend_q;
`else
          state_d = ST_FETCH;
`endif
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      inflight_q <= CNT_ZERO;
      drop_cnt_q <= CNT_ZERO;
`ifdef IF_MISALIGN_TRAP_EN
      trap_pend_q <= 1'b0;
      trap_pc_q   <= 32'h0000_0000;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef IF_MISALIGN_TRAP_EN
      trap_pend_q <= trap_pend_d;
      trap_pc_q   <= trap_pc_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus_io.redirect_valid),
    .push_i  (req_fire_s),
    .din_i   (fetch_pc_q),
    .pop_i   (rsp_take_s),
    .dout_o  (pcq_head_s),
    .count_o (pcq_count_s)
  );

  // A pop coinciding with a redirect is still consumed by decode; the clear then empties the rest.
  sync_fifo #(
    .WIDTH (OQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_queue (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus_io.redirect_valid),
    .push_i  (oq_push_s),
    .din_i   (oq_din_s),
    .pop_i   (oq_pop_s),
    .dout_o  (oq_head_s),
    .count_o (oq_count_s)
  );

  assign bus_io.imem_req_valid = req_valid_s;
  assign bus_io.imem_req_addr  = fetch_pc_q;
  assign bus_io.if_valid       = (oq_count_s != CNT_ZERO);
  assign bus_io.if_pc          = oq_head_s[63:32];
  assign bus_io.if_instr       = oq_head_s[31:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: fixed-latency imem model (word = addr + 0x1000_0000)
// and cycle-numbered checks; cycle 1 is the first cycle with rst low.
`timescale 1ns/1ps
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int req_cnt = 0;
  int mem_lat = 1;
  int base_cnt;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk1({tag, "_valid"}, bus.if_valid, 1'b1);
    chk32({tag, "_pc"}, bus.if_pc, pc);
    chk32({tag, "_instr"}, bus.if_instr, pc + 32'h1000_0000);
  endtask

  // In-order imem: responds mem_lat cycles after acceptance; reset drops everything pending.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0000_0000;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #2;
      if (!rst && (mq_due.size() > 0) && (mq_due[0] <= cyc)) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mq_addr[0] + 32'h1000_0000;
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0000_0000;
      end
      @(negedge clk);
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        mq_addr.push_back(bus.imem_req_addr);
        mq_due.push_back(cyc + mem_lat);
        req_cnt = req_cnt + 1;
      end
    end
  end

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0000_0000;
    bus.if_ready       = 1'b0;

    // Reset values.
    repeat (3) step();
    sample();
    chk1 ("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk32("rst_req_addr",  bus.imem_req_addr, 32'h0000_0000);
    chk1 ("rst_if_valid",  bus.if_valid, 1'b0);
    chk32("rst_if_instr",  bus.if_instr, 32'h0000_0000);
    chk32("rst_if_pc",     bus.if_pc, 32'h0000_0000);
`ifdef IF_MISALIGN_TRAP_EN
    chk1 ("rst_if_misalign", bus.if_misalign, 1'b0);
`endif

    // L=1 streaming: requests 0,4,8,... from cycle 1, if_pc 0,4,8,... from cycle 3.
    step(); rst = 1'b0; bus.if_ready = 1'b1;
    sample();
    chk1 ("c1_req_valid", bus.imem_req_valid, 1'b1);
    chk32("c1_req_addr",  bus.imem_req_addr, 32'h0000_0000);
    step(); sample();
    chk32("c2_req_addr", bus.imem_req_addr, 32'h0000_0004);
    chk1 ("c2_if_valid", bus.if_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(); sample();
      chk_out("stream", 32'(4 * k));
      chk32("stream_req_addr", bus.imem_req_addr, 32'(8 + 4 * k));
    end

    // Mid-operation reset.
    step(); rst = 1'b1;
    sample();
    chk1("midrst_req_valid", bus.imem_req_valid, 1'b0);
    step(); sample();
    chk1 ("midrst_if_valid", bus.if_valid, 1'b0);
    chk32("midrst_if_pc",    bus.if_pc, 32'h0000_0000);
    chk32("midrst_if_instr", bus.if_instr, 32'h0000_0000);
    chk32("midrst_req_addr", bus.imem_req_addr, 32'h0000_0000);

    // Stalled decode for 10 cycles: exactly FIFO_DEPTH requests, head held at pc 0.
    step(); rst = 1'b0; bus.if_ready = 1'b0; base_cnt = req_cnt;
    repeat (4) step();
    sample();
    chk_out("stall_c5", 32'h0000_0000);
    repeat (5) step();
    chk32("stall_req_count", 32'(req_cnt - base_cnt), 32'd4);
    sample();
    chk_out("stall_c10", 32'h0000_0000);
    chk1("stall_req_valid", bus.imem_req_valid, 1'b0);

    // Release decode: drains 0..12 then continues with 16 without a gap.
    step(); bus.if_ready = 1'b1;
    sample();
    chk_out("drain0", 32'h0000_0000);
    for (int k = 1; k < 5; k++) begin
      step(); sample();
      chk_out("drain", 32'(4 * k));
    end

    // L=3, redirect to 0x100 with two requests in flight.
    step(); rst = 1'b1; mem_lat = 3;
    step();
    step(); rst = 1'b0;                                   // c1: req 0
    step();                                               // c2: req 4
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100;  // c3
    sample();
    chk1("redir_req_forced_low", bus.imem_req_valid, 1'b0);
    step(); bus.redirect_valid = 1'b0;                    // c4: stale 0 dropped
    sample();
    chk1("flush_c4_req_valid", bus.imem_req_valid, 1'b0);
    chk1("flush_c4_if_valid",  bus.if_valid, 1'b0);
    step(); sample();                                     // c5: stale 4 dropped
    chk1("flush_c5_req_valid", bus.imem_req_valid, 1'b0);
    chk1("flush_c5_if_valid",  bus.if_valid, 1'b0);
    step(); sample();                                     // c6
    chk1 ("refetch_req_valid", bus.imem_req_valid, 1'b1);
    chk32("refetch_req_addr",  bus.imem_req_addr, 32'h0000_0100);
    for (int k = 0; k < 3; k++) begin                     // c7..c9
      step(); sample();
      chk1("refetch_wait_if_valid", bus.if_valid, 1'b0);
    end

    // c10: head 0x100 popped while response 0x104 arrives and a redirect to 0x200 fires.
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
    sample();
    chk_out("redir_pop", 32'h0000_0100);
    chk1("redir_pop_req_valid", bus.imem_req_valid, 1'b0);
    step(); bus.redirect_valid = 1'b0;                    // c11
    sample();
    chk1("redir2_c11_if_valid",  bus.if_valid, 1'b0);
    chk1("redir2_c11_req_valid", bus.imem_req_valid, 1'b0);
    step(); sample();                                     // c12
    chk1("redir2_c12_if_valid",  bus.if_valid, 1'b0);
    chk1("redir2_c12_req_valid", bus.imem_req_valid, 1'b0);
    step(); sample();                                     // c13
    chk1 ("redir2_req_valid", bus.imem_req_valid, 1'b1);
    chk32("redir2_req_addr",  bus.imem_req_addr, 32'h0000_0200);
    for (int k = 0; k < 3; k++) begin                     // c14..c16
      step(); sample();
      chk1("redir2_wait_if_valid", bus.if_valid, 1'b0);
    end
    step(); sample();                                     // c17
    chk_out("redir2_first", 32'h0000_0200);

    // L=1, fetch_pc wrap from 0xFFFF_FFF8.
    step(); rst = 1'b1; mem_lat = 1;
    step();
    step(); rst = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;  // c1
    sample();
    chk1("wrap_c1_req_valid", bus.imem_req_valid, 1'b0);
    step(); bus.redirect_valid = 1'b0;                    // c2
    sample();
    chk1 ("wrap_c2_req_valid", bus.imem_req_valid, 1'b1);
    chk32("wrap_c2_addr", bus.imem_req_addr, 32'hFFFF_FFF8);
    step(); sample();                                     // c3
    chk32("wrap_c3_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    step(); sample();                                     // c4
    chk32("wrap_c4_addr", bus.imem_req_addr, 32'h0000_0000);
    chk_out("wrap_c4", 32'hFFFF_FFF8);
    step(); sample();                                     // c5
    chk_out("wrap_c5", 32'hFFFF_FFFC);

`ifdef IF_MISALIGN_TRAP_EN
    // c6: misaligned redirect -> one trap entry, then no fetch until the next redirect.
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0102;
    sample();
    chk_out("mis_c6", 32'h0000_0000);
    step(); bus.redirect_valid = 1'b0;                    // c7
    sample();
    chk1("mis_c7_req_valid", bus.imem_req_valid, 1'b0);
    chk1("mis_c7_if_valid",  bus.if_valid, 1'b0);
    step(); sample();                                     // c8
    chk1 ("mis_valid",    bus.if_valid, 1'b1);
    chk32("mis_pc",       bus.if_pc, 32'h0000_0102);
    chk32("mis_instr",    bus.if_instr, 32'h0000_0013);
    chk1 ("mis_flag",     bus.if_misalign, 1'b1);
    chk1 ("mis_c8_req_valid", bus.imem_req_valid, 1'b0);
    for (int k = 0; k < 2; k++) begin                     // c9..c10
      step(); sample();
      chk1("halt_req_valid", bus.imem_req_valid, 1'b0);
      chk1("halt_if_valid",  bus.if_valid, 1'b0);
    end
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;  // c11
    sample();
    chk1("unhalt_c11_req_valid", bus.imem_req_valid, 1'b0);
    step(); bus.redirect_valid = 1'b0;                    // c12
    sample();
    chk1 ("unhalt_req_valid", bus.imem_req_valid, 1'b1);
    chk32("unhalt_req_addr",  bus.imem_req_addr, 32'h0000_0200);
`else
    // c6: misaligned redirect -> low bits silently cleared, fetch resumes at 0x300.
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0302;
    sample();
    chk_out("align_c6", 32'h0000_0000);
    chk1("align_c6_req_valid", bus.imem_req_valid, 1'b0);
    step(); bus.redirect_valid = 1'b0;                    // c7
    sample();
    chk1 ("align_req_valid", bus.imem_req_valid, 1'b1);
    chk32("align_req_addr",  bus.imem_req_addr, 32'h0000_0300);
    chk1 ("align_c7_if_valid", bus.if_valid, 1'b0);
    step(); sample();                                     // c8
    chk1("align_c8_if_valid", bus.if_valid, 1'b0);
    step(); sample();                                     // c9
    chk_out("align_first", 32'h0000_0300);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
